// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and defaults for the instruction fetch stage: IF/ID bundle, fetch FSM states,
// reset PC, sequential step and the bubble word.
package instruction_fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STEP  = 32'd4;
    localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // Redirect targets are byte addresses; fetches are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls, instruction memory port and IF/ID outputs.
// The statistics counters exist only when FETCH_STATS_EN is defined.
interface instruction_fetch_stage_if;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    modport master (
        input  freeze, branch_taken, branch_addr, imem_data,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count, stall_count
    );
    modport slave (
        output freeze, branch_taken, branch_addr, imem_data,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count, stall_count
    );
`else
    modport master (
        input  freeze, branch_taken, branch_addr, imem_data,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid
    );
    modport slave (
        output freeze, branch_taken, branch_addr, imem_data,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid
    );
`endif
endinterface

// File: rtl/instruction_fetch_stage_if_id_reg.sv
// Generic pipeline register for an IF/ID-style bundle; flush beats hold, hold beats load.
module if_id_reg
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    localparam if_id_t BUBBLE = '{pc: 32'h0, instr: NOP_WORD, valid: 1'b0};

    if_id_t stage_q;
    if_id_t stage_d;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = BUBBLE;
        end else if (!hold) begin
            stage_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, presents it to a combinational instruction memory
// and captures the returned word into IF/ID. Optional counters under FETCH_STATS_EN.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEF_PC_STEP,
    parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic                          clk,
    input  logic                          rst,
    instruction_fetch_stage_if.master     bus
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         run;
    logic         flush;
    logic         hold;
    logic         load;
    if_id_t       if_id_d;
    if_id_t       if_id_q;

    // A redirect wins over a stall; BOOT ignores both and only inserts one bubble.
    assign run   = (state_q == RUN);
    assign flush = run && bus.branch_taken;
    assign hold  = !run || bus.freeze;
    assign load  = run && !bus.branch_taken && !bus.freeze;

    always_comb begin
        state_d = RUN;
        pc_d    = pc_q;
        if (flush) begin
            pc_d = align_word(bus.branch_addr);
        end else if (load) begin
            pc_d = pc_q + PC_STEP;
        end
        if_id_d = '{pc: pc_q + PC_STEP, instr: bus.imem_data, valid: 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .flush (flush),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_pc    = if_id_q.pc;
    assign bus.if_id_instr = if_id_q.instr;
    assign bus.if_id_valid = if_id_q.valid;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q;
    logic [31:0] fetch_count_d;
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + (load ? 32'd1 : 32'd0);
        stall_count_d = stall_count_q + ((run && bus.freeze && !bus.branch_taken) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.fetch_count = fetch_count_q;
    assign bus.stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage (build with +define+FETCH_STATS_EN for counters).
module tb_instruction_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    instruction_fetch_stage_if bus ();

    instruction_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] imem_model(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            default: return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
        endcase
    endfunction

    assign bus.imem_data = imem_model(bus.imem_addr);

    // Reference model: architectural view of the stage.
    bit          booted;
    logic [31:0] exp_pc;
    logic [31:0] exp_if_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;

    task automatic model_reset();
        booted    = 1'b0;
        exp_pc    = 32'h0;
        exp_if_pc = 32'h0;
        exp_instr = 32'h0;
        exp_valid = 1'b0;
        exp_fetch = 32'h0;
        exp_stall = 32'h0;
    endtask

    task automatic step(input logic fr, input logic br, input logic [31:0] ba);
        bus.freeze       = fr;
        bus.branch_taken = br;
        bus.branch_addr  = ba;
        @(posedge clk);
        if (!booted) begin
            booted = 1'b1;
        end else if (br) begin
            exp_pc    = {ba[31:2], 2'b00};
            exp_if_pc = 32'h0;
            exp_instr = 32'h0;
            exp_valid = 1'b0;
        end else if (fr) begin
            exp_stall = exp_stall + 1;
        end else begin
            exp_if_pc = exp_pc + 4;
            exp_instr = imem_model(exp_pc);
            exp_valid = 1'b1;
            exp_pc    = exp_pc + 4;
            exp_fetch = exp_fetch + 1;
        end
        #1;
        cyc++;
        $display("cyc %0d fr=%0b br=%0b ba=%h -> addr=%h if_pc=%h instr=%h v=%0b",
                 cyc, fr, br, ba, bus.imem_addr, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.freeze = 0; bus.branch_taken = 0; bus.branch_addr = 0;
        model_reset();
        #2;
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.imem_addr); end
        total++; if (bus.if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.if_id_valid); end
        total++; if (bus.if_id_instr !== 32'h0 || bus.if_id_pc !== 32'h0) begin
            bad++; $display("FAIL reset_ifid got pc=%h instr=%h want 0/0", bus.if_id_pc, bus.if_id_instr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_sequential();
        logic [31:0] want_pc [3];
        logic [31:0] want_in [3];
        want_pc = '{32'h4, 32'h8, 32'hC};
        want_in = '{32'h11, 32'h22, 32'h33};
        step(0, 1, 32'h100);  // BOOT ignores branch
        total++; if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
            bad++; $display("FAIL boot_bubble got v=%b addr=%h want v=0 addr=0", bus.if_id_valid, bus.imem_addr); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            total++; if (bus.if_id_pc !== want_pc[i] || bus.if_id_instr !== want_in[i] || bus.if_id_valid !== 1'b1) begin
                bad++; $display("FAIL seq_fetch%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=1",
                                i, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, want_pc[i], want_in[i]); end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0);
            total++; if (bus.imem_addr !== 32'h8 || bus.if_id_pc !== 32'h8 || bus.if_id_instr !== 32'h22) begin
                bad++; $display("FAIL freeze_hold%0d got addr=%h pc=%h instr=%h want 8/8/22",
                                i, bus.imem_addr, bus.if_id_pc, bus.if_id_instr); end
        end
        step(0, 0, 0);
        total++; if (bus.if_id_pc !== 32'hC || bus.if_id_instr !== 32'h33 || bus.imem_addr !== 32'hC) begin
            bad++; $display("FAIL freeze_resume got pc=%h instr=%h addr=%h want C/33/C",
                            bus.if_id_pc, bus.if_id_instr, bus.imem_addr); end
    endtask

    task automatic test_branch();
        step(1, 1, 32'h40);
        total++; if (bus.imem_addr !== 32'h40 || bus.if_id_instr !== 32'h0 || bus.if_id_valid !== 1'b0) begin
            bad++; $display("FAIL branch_flush got addr=%h instr=%h v=%b want 40/0/0",
                            bus.imem_addr, bus.if_id_instr, bus.if_id_valid); end
        step(0, 0, 0);
        total++; if (bus.if_id_pc !== 32'h44 || bus.if_id_valid !== 1'b1) begin
            bad++; $display("FAIL branch_next got pc=%h v=%b want 44/1", bus.if_id_pc, bus.if_id_valid); end
        step(0, 1, 32'h43);
        total++; if (bus.imem_addr !== 32'h40) begin
            bad++; $display("FAIL branch_align got=%h want=40", bus.imem_addr); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'h200 + 32'(i * 16));
            total++; if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'h200 + 32'(i * 16)) begin
                bad++; $display("FAIL b2b_branch%0d got v=%b addr=%h want v=0 addr=%h",
                                i, bus.if_id_valid, bus.imem_addr, 32'h200 + 32'(i * 16)); end
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 32'hFFFF_FFFE);
        step(0, 0, 0);
        total++; if (bus.imem_addr !== 32'h0 || bus.if_id_pc !== 32'h0 || bus.if_id_valid !== 1'b1) begin
            bad++; $display("FAIL pc_wrap got addr=%h pc=%h v=%b want 0/0/1",
                            bus.imem_addr, bus.if_id_pc, bus.if_id_valid); end
    endtask

    task automatic test_random();
        logic fr, br;
        logic [31:0] ba;
        for (int i = 0; i < 300; i++) begin
            fr = ($urandom_range(3) == 0);
            br = ($urandom_range(7) == 0);
            ba = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step(fr, br, ba);
            total++; if (bus.imem_addr !== exp_pc || bus.if_id_pc !== exp_if_pc ||
                         bus.if_id_instr !== exp_instr || bus.if_id_valid !== exp_valid) begin
                bad++; $display("FAIL rand%0d got addr=%h pc=%h instr=%h v=%b want %h/%h/%h/%b",
                                i, bus.imem_addr, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid,
                                exp_pc, exp_if_pc, exp_instr, exp_valid); end
`ifdef FETCH_STATS_EN
            total++; if (bus.fetch_count !== exp_fetch || bus.stall_count !== exp_stall) begin
                bad++; $display("FAIL rand_stats%0d got f=%0d s=%0d want f=%0d s=%0d",
                                i, bus.fetch_count, bus.stall_count, exp_fetch, exp_stall); end
`endif
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        total++; if (bus.imem_addr !== 32'h0 || bus.if_id_valid !== 1'b0 ||
                     bus.if_id_pc !== 32'h0 || bus.if_id_instr !== 32'h0) begin
            bad++; $display("FAIL async_reset got addr=%h pc=%h instr=%h v=%b want all 0",
                            bus.imem_addr, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        step(0, 0, 0);
        total++; if (bus.if_id_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
            bad++; $display("FAIL async_reboot got v=%b addr=%h want 0/0", bus.if_id_valid, bus.imem_addr); end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        do_reset();
        step(1, 0, 0);  // BOOT edge is not counted
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(1, 1, 32'h80);
        total++; if (bus.fetch_count !== 32'd5 || bus.stall_count !== 32'd3) begin
            bad++; $display("FAIL stats got f=%0d s=%0d want f=5 s=3", bus.fetch_count, bus.stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_freeze();
        test_branch();
        test_wrap();
        test_random();
        test_async_reset();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front end of the 5-stage pipeline, directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned byte address into the instruction memory, which is combinational.
- Captures the returned word into the IF/ID pipeline register.
- Supports stall (freeze) from hazard detection and redirect/flush from the branch unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be zero.
- PC_STEP, 4, byte increment per sequential fetch.
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush or reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous assert, active-low; synchronous release.
- freeze  input  1  hazard stall: hold PC and IF/ID contents.
- branch_taken  input  1  redirect request from the branch unit.
- branch_addr  input  32  redirect target, byte address.
- imem_addr  output  32  byte address to instruction memory; equals pc.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- if_id_pc  output  32  registered pc+PC_STEP of the captured instruction.
- if_id_instr  output  32  registered instruction.
- if_id_valid  output  1  1 = IF/ID holds a real fetched instruction.
- fetch_count  output  32  present only with FETCH_STATS_EN.
- stall_count  output  32  present only with FETCH_STATS_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; if_id_pc=0; if_id_instr=NOP_WORD; if_id_valid=0.
  - FSM state=BOOT; counters=0.
- FSM states:
  - BOOT: the first edge after reset release inserts a bubble: valid stays 0 and pc is held. Next state is RUN. Branch inputs are ignored in BOOT.
  - RUN: normal operation per the priority list below.
- Priority per rising edge in RUN, highest first:
  1. branch_taken=1: pc<=branch_addr with bits [1:0] forced to 00; if_id_instr<=NOP_WORD; if_id_valid<=0; if_id_pc<=0. This applies even when freeze=1 (flush overrides stall).
  2. freeze=1: pc and all IF/ID registers hold.
  3. Otherwise: if_id_instr<=imem_data; if_id_pc<=pc+PC_STEP; if_id_valid<=1; pc<=pc+PC_STEP.
- imem_addr is a continuous copy of pc. Instruction-to-IF/ID latency is one cycle after the address is presented.
- PC arithmetic is unsigned 32-bit with wrap-around: 32'hFFFF_FFFC+4 gives 0. No bounds check against memory depth; that is the memory's responsibility.
- Back-to-back branches: each taken branch redirects again, and valid stays 0 throughout.
- Reset asserted mid-operation discards any in-flight IF/ID content immediately; there is no waiting for the clock.
- No outputs are X after reset; every register has a reset value.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined:
  - fetch_count increments on every RUN edge that loads a valid instruction.
  - stall_count increments on every RUN edge with freeze=1 and branch_taken=0.
  - Both counters are 32-bit, wrap silently, and reset to 0.
- When undefined: both ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - NOP_WORD constant.
  - RESET_PC default.
  - PC_STEP.
  - IF/ID bundle typedef: pc, instr, valid.
  - Fetch FSM state enum: BOOT, RUN.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with hold/flush controls, reusable for the other stage registers. PC logic and the FSM stay in the top.

Test Plan:
- Release reset; imem returns 32'h11,22,33 for addresses 0,4,8 -> BOOT bubble with valid=0; then if_id_pc=4,8,12 with instr 11,22,33 and valid=1.
- freeze=1 for 2 cycles at pc=8 -> imem_addr stays 8 and IF/ID holds pc 8, instr 22; resumes with pc 12 after release.
- branch_taken=1 with branch_addr=32'h40 and freeze=1 simultaneously -> next cycle imem_addr=32'h40, if_id_instr=0, valid=0; following cycle if_id_pc=32'h44.
- branch_addr=32'h43 -> pc=32'h40 (alignment forced).
- Assert rst between clock edges mid-run -> outputs return to reset values immediately, before the next edge.
- With FETCH_STATS_EN: run 5 fetches, 3 freeze cycles, 1 branch -> fetch_count=5, stall_count=3.
